serial_adder_nbit: RTL and testbench
====================================

# serial_adder_nbit

Bit-serial, parametrised N-bit adder/subtractor. It uses one 1-bit full-adder slice for one bit per clock, LSB first, over WIDTH cycles. Operands enter through a valid/ready handshake. The result leaves through a second valid/ready handshake with carry-out and signed overflow. It is the area-lean successor to the combinational ripple adder, for datapaths where latency is cheaper than gates.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  input  1  operands a, b, sub are valid.
- in_ready  output  1  block can accept operands; high exactly in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: A+B, 1: A−B (two's complement).
- out_valid  output  1  result valid; high exactly in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result; meaningful only while out_valid=1.
- c_out  output  1  carry out of the MSB; for subtract, 1 = no borrow (A ≥ B unsigned).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE=0, RUN=1, DONE=2. State 3 is unreachable and recovers to IDLE on the next edge.
- IDLE:
  - On in_valid && in_ready, latch a into shift register A_sh and b XOR {WIDTH{sub}} into B_sh.
  - Set carry = sub, bit counter cnt = 0, sum register = 0, then go to RUN.
- RUN, each cycle:
  - The full-adder slice takes A_sh[0], B_sh[0] and carry.
  - Shift its sum bit into the sum register MSB (right shift).
  - Shift A_sh and B_sh right by one.
  - Store the slice carry into carry and increment cnt.
  - When cnt == WIDTH−1, that cycle is the last bit. Also register c_msb_in = carry before the update, c_out = slice carry, ovf = c_msb_in XOR slice carry, then go to DONE.
- DONE:
  - sum, c_out and ovf hold steady.
  - On out_ready, go to IDLE.
  - in_valid is ignored; in_ready is 0.
- Arithmetic: result is modulo 2^WIDTH. No saturation.
- Counter width is $clog2(WIDTH).

## Timing
- Reset values: state = IDLE, so in_ready = 1 from the first post-reset cycle. out_valid = 0, sum = 0, c_out = 0, ovf = 0, cnt = 0, carry = 0.
- in_ready and out_valid are decoded directly from registered state with no combinational path from inputs.
- Latency: operands accepted at edge E0 give out_valid = 1 after edge E_WIDTH, i.e. WIDTH cycles.
- Throughput: one result per WIDTH+2 cycles minimum (accept, WIDTH bit cycles, DONE with out_ready=1 on first cycle, IDLE). Back-to-back overlap is not supported.
- Backpressure: out_valid stays high and sum, c_out, ovf stay unchanged for any number of out_ready=0 cycles.
- Reset mid-operation: rst_n low on any edge in RUN or DONE aborts. The block returns to the reset values on that edge, the partial result is discarded and no out_valid pulse follows.
- in_valid asserted while rst_n = 0 is not accepted.
- sum may change every cycle in RUN. The consumer must sample only while out_valid = 1.

## Structure
- Shared package/header adder_defs: state encodings ST_IDLE, ST_RUN, ST_DONE (2-bit) and the WIDTH legality bounds.
- One sub-module: the existing full_adder_1bit, instantiated once as the bit slice. No other hierarchy.
- Top level holds the FSM, the counter, the three shift registers and the result flags.

## Test plan
- WIDTH=8, a=100, b=27, sub=0 → exactly 8 cycles after accept: out_valid=1, sum=127, c_out=0, ovf=0.
- WIDTH=8:
  - 100+28 → sum=0x80, ovf=1, c_out=0.
  - 0xFF+0x01 → sum=0x00, c_out=1, ovf=0.
- WIDTH=8, sub=1:
  - 5−7 → sum=0xFE, c_out=0, ovf=0.
  - 0x80−0x01 → sum=0x7F, c_out=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while pulsing in_valid.
  - Result is stable, in_ready=0 and no operand is accepted.
  - When out_ready goes high, the next cycle is IDLE with in_ready=1.
- Reset: drop rst_n for one edge after bit 3 of a RUN.
  - All outputs go to reset values and no out_valid follows.
  - A new operation 3+4 then completes with sum=7.
- Sweep: WIDTH=2, 8, 32 with 1000 random add/sub operations each, checked against a reference model on sum, c_out and ovf.

Source files
------------

// File: rtl/serial_adder_nbit_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding,
// legal WIDTH bounds and the bit-counter sizing rule.
package serial_adder_nbit_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DONE   = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

    // The bit counter counts 0..WIDTH-1, so $clog2(WIDTH) bits, never fewer than one.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic bit width_legal(input int width);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_adder_nbit_if.sv
// Operand and result handshakes of the serial adder, bundled as one interface.
interface serial_adder_nbit_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );

endinterface

// File: rtl/serial_adder_nbit_full_adder.sv
// Single-bit full adder used as the one arithmetic slice of the serial adder.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder_nbit.sv
// Bit-serial N-bit adder/subtractor: one full-adder slice processes one bit per
// clock, LSB first, between a valid/ready operand handshake and a result handshake.
module serial_adder_nbit
    import serial_adder_nbit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_nbit_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             c_out_q;
    logic             ovf_q;
    logic             slice_sum;
    logic             slice_carry;
    logic             accept;
    logic             last_bit;

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.sum       = sum_sh;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;

    assign accept   = bus.in_valid && (state == ST_IDLE);
    assign last_bit = (state == ST_RUN) && (cnt == CNT_LAST);

    full_adder_1bit u_slice (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry),
        .s     (slice_sum),
        .c_out (slice_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The unused fourth encoding falls back to IDLE so a corrupted state self-heals.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.in_valid)  state_next = ST_RUN;
            ST_RUN:  if (last_bit)      state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted on load and the +1 enters as the initial carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b ^ {WIDTH{bus.sub}};
            sum_sh <= '0;
            cnt    <= '0;
            carry  <= bus.sub;
        end else if (state == ST_RUN) begin
            sum_sh <= {slice_sum, sum_sh[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= slice_carry;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                c_out_q <= slice_carry;
                ovf_q   <= carry ^ slice_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Self-checking bench: three adder instances (WIDTH 2, 8, 32) checked against an
// arithmetic reference model with directed corner cases and random sweeps.
module tb_serial_adder_nbit;

    logic        clk;
    logic        rst_n;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        op_sub;
    logic        op_valid;
    logic        rdy;
    int          sel;

    logic [63:0] obs_sum;
    logic        obs_c_out;
    logic        obs_ovf;
    logic        obs_in_ready;
    logic        obs_out_valid;

    int n_vectors;
    int n_miss;

    serial_adder_nbit_if #(.WIDTH(2))  bus2 ();
    serial_adder_nbit_if #(.WIDTH(8))  bus8 ();
    serial_adder_nbit_if #(.WIDTH(32)) bus32 ();

    serial_adder_nbit #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
    serial_adder_nbit #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder_nbit #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    assign bus2.in_valid   = op_valid && (sel == 2);
    assign bus2.a          = op_a[1:0];
    assign bus2.b          = op_b[1:0];
    assign bus2.sub        = op_sub;
    assign bus2.out_ready  = rdy;
    assign bus8.in_valid   = op_valid && (sel == 8);
    assign bus8.a          = op_a[7:0];
    assign bus8.b          = op_b[7:0];
    assign bus8.sub        = op_sub;
    assign bus8.out_ready  = rdy;
    assign bus32.in_valid  = op_valid && (sel == 32);
    assign bus32.a         = op_a[31:0];
    assign bus32.b         = op_b[31:0];
    assign bus32.sub       = op_sub;
    assign bus32.out_ready = rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obs_sum       = '0;
        obs_c_out     = 1'b0;
        obs_ovf       = 1'b0;
        obs_in_ready  = 1'b0;
        obs_out_valid = 1'b0;
        case (sel)
            2: begin
                obs_sum = 64'(bus2.sum);   obs_c_out = bus2.c_out;  obs_ovf = bus2.ovf;
                obs_in_ready = bus2.in_ready;  obs_out_valid = bus2.out_valid;
            end
            8: begin
                obs_sum = 64'(bus8.sum);   obs_c_out = bus8.c_out;  obs_ovf = bus8.ovf;
                obs_in_ready = bus8.in_ready;  obs_out_valid = bus8.out_valid;
            end
            32: begin
                obs_sum = 64'(bus32.sum);  obs_c_out = bus32.c_out; obs_ovf = bus32.ovf;
                obs_in_ready = bus32.in_ready; obs_out_valid = bus32.out_valid;
            end
            default: ;
        endcase
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_vectors++;
        assert (observed === expected) else begin
            n_miss++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: modular sum, unsigned carry/no-borrow, and true signed result range.
    task automatic model(input int w, input logic [63:0] a_in, input logic [63:0] b_in, input logic s,
                         output logic [63:0] exp_sum, output logic exp_co, output logic exp_ov);
        longint unsigned mask;
        longint unsigned ua;
        longint unsigned ub;
        longint          half;
        longint          sa;
        longint          sb;
        longint          r;
        mask = (longint'(1) << w) - 1;
        ua   = a_in & mask;
        ub   = b_in & mask;
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? longint'(ua) - 2 * half : longint'(ua);
        sb   = (ub >= half) ? longint'(ub) - 2 * half : longint'(ub);
        if (s) begin
            exp_sum = (ua - ub) & mask;
            exp_co  = (ua >= ub);
            r       = sa - sb;
        end else begin
            exp_sum = (ua + ub) & mask;
            exp_co  = ((ua + ub) >> w) != 0;
            r       = sa + sb;
        end
        exp_ov = (r > half - 1) || (r < -half);
    endtask

    // Called one time unit after a rising edge with the selected instance idle;
    // returns in the first DONE cycle.
    task automatic apply_stimulus(input int w, input logic [63:0] a_in, input logic [63:0] b_in, input logic s,
                                  input logic [63:0] exp_sum, input logic exp_co, input logic exp_ov,
                                  input string tag);
        int lat;
        sel      = w;
        op_a     = a_in;
        op_b     = b_in;
        op_sub   = s;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        lat = 0;
        while (!obs_out_valid && lat < w + 4) begin
            @(posedge clk);
            #1 lat++;
        end
        check_output({tag, "_latency"}, 64'(lat), 64'(w));
        check_output({tag, "_sum"},   obs_sum,   exp_sum);
        check_output({tag, "_c_out"}, 64'(obs_c_out), 64'(exp_co));
        check_output({tag, "_ovf"},   64'(obs_ovf),   64'(exp_ov));
    endtask

    initial begin
        logic [63:0] es;
        logic        ec;
        logic        eo;
        int          seen;
        n_vectors = 0;
        n_miss    = 0;
        sel       = 8;
        op_a      = '0;
        op_b      = '0;
        op_sub    = 1'b0;
        op_valid  = 1'b1;
        rdy       = 1'b1;
        rst_n     = 1'b0;

        // in_valid is held high through reset and must not be taken
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_in_ready",  64'(obs_in_ready),  64'd1);
        check_output("rst_out_valid", 64'(obs_out_valid), 64'd0);
        check_output("rst_sum",       obs_sum,            64'd0);
        check_output("rst_c_out",     64'(obs_c_out),     64'd0);
        check_output("rst_ovf",       64'(obs_ovf),       64'd0);
        op_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1 check_output("idle_in_ready", 64'(obs_in_ready), 64'd1);

        apply_stimulus(8, 64'd100, 64'd27, 1'b0, 64'd127, 1'b0, 1'b0, "add_100_27");
        @(posedge clk);
        #1 check_output("after_done_in_ready", 64'(obs_in_ready), 64'd1);
        apply_stimulus(8, 64'd100, 64'd28, 1'b0, 64'h80, 1'b0, 1'b1, "add_ovf");
        @(posedge clk);
        #1;
        apply_stimulus(8, 64'hFF, 64'h01, 1'b0, 64'h00, 1'b1, 1'b0, "add_carry");
        @(posedge clk);
        #1;
        apply_stimulus(8, 64'd5, 64'd7, 1'b1, 64'hFE, 1'b0, 1'b0, "sub_borrow");
        @(posedge clk);
        #1;
        apply_stimulus(8, 64'h80, 64'h01, 1'b1, 64'h7F, 1'b1, 1'b1, "sub_ovf");
        @(posedge clk);
        #1;

        // Backpressure: result held, new operands offered but refused
        rdy = 1'b0;
        apply_stimulus(8, 64'd50, 64'd60, 1'b0, 64'd110, 1'b0, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            op_a     = 64'(i + 1);
            op_b     = 64'(i + 2);
            op_valid = 1'b1;
            @(posedge clk);
            #1;
            check_output($sformatf("bp_out_valid_%0d", i), 64'(obs_out_valid), 64'd1);
            check_output($sformatf("bp_in_ready_%0d", i),  64'(obs_in_ready),  64'd0);
            check_output($sformatf("bp_sum_%0d", i),       obs_sum,            64'd110);
        end
        op_valid = 1'b0;
        rdy      = 1'b1;
        @(posedge clk);
        #1;
        check_output("bp_release_in_ready",  64'(obs_in_ready),  64'd1);
        check_output("bp_release_out_valid", 64'(obs_out_valid), 64'd0);
        @(posedge clk);
        #1 check_output("bp_no_accept", 64'(obs_in_ready), 64'd1);

        // Leave c_out=1 behind, then abort a run after its bit 3
        apply_stimulus(8, 64'hFF, 64'h01, 1'b0, 64'h00, 1'b1, 1'b0, "pre_abort");
        @(posedge clk);
        #1;
        sel      = 8;
        op_a     = 64'hF0;
        op_b     = 64'h3C;
        op_sub   = 1'b0;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("abort_in_ready",  64'(obs_in_ready),  64'd1);
        check_output("abort_out_valid", 64'(obs_out_valid), 64'd0);
        check_output("abort_sum",       obs_sum,            64'd0);
        check_output("abort_c_out",     64'(obs_c_out),     64'd0);
        check_output("abort_ovf",       64'(obs_ovf),       64'd0);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 if (obs_out_valid) seen++;
        end
        check_output("abort_no_out_valid", 64'(seen), 64'd0);
        apply_stimulus(8, 64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0, "post_abort");
        @(posedge clk);
        #1;

        // WIDTH-specific extremes and random sweeps
        apply_stimulus(2, 64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b1, "w2_ovf");
        @(posedge clk);
        #1;
        apply_stimulus(32, 64'hFFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, "w32_carry");
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            int w;
            w = (k == 0) ? 2 : (k == 1) ? 8 : 32;
            for (int n = 0; n < 1000; n++) begin
                logic [63:0] ra;
                logic [63:0] rb;
                logic        rs;
                ra = {32'd0, $urandom};
                rb = {32'd0, $urandom};
                rs = 1'($urandom_range(0, 1));
                model(w, ra, rb, rs, es, ec, eo);
                apply_stimulus(w, ra, rb, rs, es, ec, eo, $sformatf("sweep_w%0d_n%0d", w, n));
                @(posedge clk);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miss);
        $finish;
    end

endmodule
